uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have clock i_clk (input, 1): all state updates on its rising edge.
REQ-002 The block SHALL have reset i_rst (input, 1): asynchronous, active-high.
REQ-003 The block SHALL have i_data (input, 8): byte to transmit, sampled on handshake.
REQ-004 The block SHALL have i_valid (input, 1): upstream stream valid.
REQ-005 The block SHALL have o_ready (output, 1): block can accept a byte.
REQ-006 The block SHALL have i_txpulse (input, 1): single-cycle bit-rate strobe, one per bit period, from the shared baud generator.
REQ-007 The block SHALL have o_txd (output, 1): serial line, registered, idle high.
REQ-008 The block SHALL have o_busy (output, 1): high whenever a frame is pending or on the line.
REQ-009 The block SHALL have o_txdone (output, 1): one-cycle pulse at end of each stop bit.

Function
REQ-010 The FSM SHALL have states S_IDLE, S_SYNC, S_START, S_DATA, S_PARITY (macro only) and S_STOP; undefined encodings go to S_IDLE.
REQ-011 o_ready SHALL be high exactly when state is S_IDLE; o_busy SHALL be its complement.
REQ-012 A transfer SHALL occur on a cycle with i_valid=1 and o_ready=1; i_data is latched into an internal shift register and state goes to S_SYNC.
REQ-013 i_valid while o_ready=0 SHALL be ignored; i_data changes after acceptance SHALL NOT affect the frame.
REQ-014 In S_SYNC the block SHALL hold o_txd=1 until i_txpulse=1; a pulse on the acceptance cycle itself SHALL be ignored.
REQ-015 An i_txpulse in S_SYNC at cycle N SHALL give o_txd=0 (start bit) from cycle N+1, state S_START.
REQ-016 Each subsequent i_txpulse at cycle M SHALL advance to the next bit, with o_txd updating at M+1; every bit therefore lasts exactly one pulse period.
REQ-017 Data bits SHALL be sent LSB first, 8 bits, counted with a 3-bit counter wrapping 7->0 on transition out of S_DATA.
REQ-018 The stop bit SHALL drive o_txd=1 for one full pulse period; the pulse ending it SHALL return state to S_IDLE, assert o_txdone for that one cycle, and raise o_ready the next cycle.
REQ-019 In S_IDLE a simultaneous i_valid and i_txpulse SHALL accept the byte; the next frame's start bit waits for the following pulse (back-to-back gap >= 0 extra idle bits beyond alignment).
REQ-020 Without i_txpulse the block SHALL hold its current state and o_txd indefinitely.
REQ-021 o_txd SHALL be driven only from a register, never combinationally from inputs.

Reset
REQ-022 Asserting i_rst SHALL immediately set state S_IDLE, o_txd=1, o_ready=1, o_busy=0, o_txdone=0, clear bit counter and shift register.
REQ-023 Reset mid-frame SHALL abort the frame with no o_txdone pulse; the line returns high at once.
REQ-024 After reset release the first cycle SHALL accept a valid byte.

Configuration
REQ-025 Macro UART_TX_PARITY_EN SHALL, when defined, insert S_PARITY between S_DATA and S_STOP, sending one even-parity bit (XOR of the 8 data bits) for one pulse period.
REQ-026 Without UART_TX_PARITY_EN the frame SHALL be 10 bits (start, 8 data, stop) and S_PARITY logic SHALL not be built.

Verification
REQ-027 Reset then i_data=0x55, i_valid one cycle, pulses every 16 cycles -> o_txd per period: 0,1,0,1,0,1,0,1,0,1; o_txdone once; o_ready back high.
REQ-028 i_data=0xA3 with UART_TX_PARITY_EN -> 0,1,1,0,0,0,1,0,1,0(parity),1; without macro same minus parity bit.
REQ-029 Hold i_valid high with 0x00 then 0xFF -> two frames, second accepted cycle after o_ready rises, start bit aligned to next pulse, no glitch between frames.
REQ-030 i_valid=1 with i_data=0x11 during data bit 3 of a 0x0F frame -> ignored; line shows only 0x0F frame.
REQ-031 Assert i_rst during data bit 4 -> o_txd=1 same cycle, no o_txdone, o_ready=1; next byte 0x3C transmits correctly.
REQ-032 Stop i_txpulse for 100 cycles mid-frame -> o_txd frozen at current bit value; frame resumes on next pulse.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Byte-stream to asynchronous serial transmitter. Accepts a byte
//               on a valid/ready handshake and sends it LSB first as
//               start + 8 data (+ optional even parity) + stop, advancing one
//               bit per i_txpulse strobe from a shared baud generator.
//               Optional feature macro: UART_TX_PARITY_EN (adds an even-parity
//               bit between the last data bit and the stop bit).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_txpulse,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_txdone
);

    // Frame sequencer states. S_SYNC waits for the first strobe after
    // acceptance so that the start bit always lasts a full pulse period.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    // Index of the final data bit; the bit counter wraps to zero after it.
    localparam logic [2:0] c_last_bit = 3'd7;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_txd;
    logic       w_txd_nxt;
    logic       w_txdone;

`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register is
    // consumed while the data bits go out.
    logic       r_parity;
    logic       w_parity_nxt;
`endif

    // State, counter, shift register and line register; async reset returns
    // the line high immediately and abandons any frame in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit storage for the current frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    // Next-state logic. The line register is loaded with the value of the
    // bit being entered, so o_txd changes the cycle after each strobe.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_txd_nxt     = r_txd;
        w_txdone      = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                // A strobe coinciding with acceptance is deliberately not
                // used; the frame begins at the following strobe.
                if (i_valid) begin
                    w_shift_nxt   = i_data;
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = S_SYNC;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt  = ^i_data;
`endif
                end
            end

            S_SYNC: begin
                w_txd_nxt = 1'b1;
                if (i_txpulse) begin
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end

            S_START: begin
                if (i_txpulse) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end

            S_DATA: begin
                if (i_txpulse) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == c_last_bit) begin
                        w_bit_cnt_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt   = S_PARITY;
                        w_txd_nxt     = r_parity;
`else
                        w_state_nxt   = S_STOP;
                        w_txd_nxt     = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_txd_nxt     = r_shift[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (i_txpulse) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif

            S_STOP: begin
                w_txd_nxt = 1'b1;
                if (i_txpulse) begin
                    w_state_nxt = S_IDLE;
                    w_txdone    = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = 3'd0;
                w_txd_nxt     = 1'b1;
            end
        endcase
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_busy   = ~o_ready;
    assign o_txd    = r_txd;
    assign o_txdone = w_txdone;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Randomized self-checking bench for uart_tx against a
//               queue-based line model (frame = list of bit levels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam logic [31:0] FMASK = (32'd1 << FL) - 32'd1;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_txpulse;
    logic       o_txd;
    logic       o_busy;
    logic       o_txdone;

    uart_tx dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_txpulse (i_txpulse),
        .o_txd     (o_txd),
        .o_busy    (o_busy),
        .o_txdone  (o_txdone)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: a pending frame is a queue of line levels.
    logic       m_busy;
    logic       m_line;
    logic       m_bits[$];
    logic       cap_pending;
    logic [31:0] cap;
    int         cap_n;
    int         done_cnt;
    int         acc;
    int         ph;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line levels of one frame, index 0 first on the wire.
    function automatic logic [10:0] frame_vec(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    function automatic logic next_pulse(input int period);
        logic r;
        if (period == 0) begin
            r = ($urandom_range(0, 2) == 0);
        end else begin
            r = ((ph % period) == 0);
            ph++;
        end
        return r;
    endfunction

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic p);
        logic       exp_done;
        logic [10:0] fv;
        i_valid = v; i_data = d; i_txpulse = p;
        #1;
        if (cap_pending) begin
            if (cap_n < 32) cap[cap_n] = o_txd;
            cap_n++;
            cap_pending = 1'b0;
        end
        exp_done = m_busy && p && (m_bits.size() == 0);
        check("ready",  32'(o_ready),  32'(!m_busy));
        check("busy",   32'(o_busy),   32'(m_busy));
        check("txd",    32'(o_txd),    32'(m_line));
        check("txdone", 32'(o_txdone), 32'(exp_done));
        if (o_txdone) done_cnt++;
        @(posedge i_clk);
        if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                acc++;
                fv = frame_vec(d);
                for (int i = 0; i < FL; i++) m_bits.push_back(fv[i]);
            end
        end else if (p) begin
            if (m_bits.size() == 0) begin
                m_busy = 1'b0;
            end else begin
                m_line = m_bits.pop_front();
                cap_pending = 1'b1;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_txpulse = 1'b1;
        #1;
        check("rst_txd",    32'(o_txd),    32'd1);
        check("rst_ready",  32'(o_ready),  32'd1);
        check("rst_busy",   32'(o_busy),   32'd0);
        check("rst_txdone", 32'(o_txdone), 32'd0);
        m_busy = 1'b0; m_line = 1'b1; m_bits.delete(); cap_pending = 1'b0;
        i_txpulse = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] d, input int period, input logic noise,
                             input int stall_at, input int stall_len);
        int   guard;
        logic stalled;
        logic [10:0] fv;
        cap_n = 0; done_cnt = 0; cap = '0; cap_pending = 1'b0; stalled = 1'b0; guard = 0;
        step(1'b1, d, next_pulse(period));
        while (m_busy && guard < 4000) begin
            if (!stalled && stall_len > 0 && cap_n == stall_at) begin
                repeat (stall_len) step(noise & 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
                stalled = 1'b1;
            end else begin
                step(noise & 1'($urandom_range(0, 1)), 8'($urandom), next_pulse(period));
            end
            guard++;
        end
        fv = frame_vec(d);
        check("frame_timeout", 32'(m_busy), 32'd0);
        check("frame_bits", 32'(cap_n), 32'(FL));
        check("frame_val", cap & FMASK, 32'(fv) & FMASK);
        check("txdone_cnt", 32'(done_cnt), 32'd1);
    endtask

    task automatic back_to_back();
        int guard;
        logic [10:0] f0;
        logic [10:0] f1;
        logic [31:0] e;
        cap_n = 0; done_cnt = 0; acc = 0; cap = '0; cap_pending = 1'b0; guard = 0;
        while ((acc < 2 || m_busy) && guard < 4000) begin
            step(acc < 2, (acc == 0) ? 8'h00 : 8'hFF, next_pulse(16));
            guard++;
        end
        f0 = frame_vec(8'h00);
        f1 = frame_vec(8'hFF);
        e  = ((32'(f1) & FMASK) << FL) | (32'(f0) & FMASK);
        check("b2b_timeout", 32'(m_busy), 32'd0);
        check("b2b_bits", 32'(cap_n), 32'(2 * FL));
        check("b2b_val", cap, e);
        check("b2b_txdone", 32'(done_cnt), 32'd2);
    endtask

    task automatic reset_mid(input logic [7:0] d);
        int guard;
        cap_n = 0; done_cnt = 0; cap_pending = 1'b0; guard = 0;
        step(1'b1, d, next_pulse(16));
        // Six bits seen on the line: data bit 4 is now being sent.
        while (cap_n < 6 && guard < 4000) begin
            step(1'b0, 8'h00, next_pulse(16));
            guard++;
        end
        check("mid_reached", 32'(cap_n), 32'd6);
        do_reset();
        check("mid_no_txdone", 32'(done_cnt), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_txpulse = 1'b0;
        m_busy = 1'b0; m_line = 1'b1; cap_pending = 1'b0; cap = '0;
        cap_n = 0; done_cnt = 0; acc = 0; ph = 0; n_tests = 0; n_fail = 0;
        @(negedge i_clk);
        do_reset();

        run_frame(8'h55, 16, 1'b0, 0, 0);
        check("frame_55", cap & 32'h3FF, 32'h2AA);

        run_frame(8'hA3, 16, 1'b0, 0, 0);
`ifdef UART_TX_PARITY_EN
        check("frame_a3", cap & 32'h7FF, 32'b10101000110);
`else
        check("frame_a3", cap & 32'h3FF, 32'b1101000110);
`endif

        back_to_back();

        run_frame(8'h0F, 16, 1'b1, 0, 0);
        reset_mid(8'hC5);
        run_frame(8'h3C, 16, 1'b0, 0, 0);
        run_frame(8'h96, 8, 1'b0, 4, 100);
        run_frame(8'h5A, 1, 1'b1, 0, 0);

        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
            run_frame(8'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, FL - 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
